// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one word-aligned data memory between the load/store port (0)
// and a secondary master (1); one access per IDLE/ACCESS pair with registered done.
module dmem_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,

    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        last_q, last_d;
    logic        sel_q, sel_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        m0_done_q, m0_done_d;
    logic        m1_done_q, m1_done_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;

    logic        elig0;
    logic        elig1;
    logic        pick;
    logic        grant;

    // A port whose done is high is finishing its access and must not be re-granted now.
    always_comb begin
        elig0 = m0_req & ~m0_done_q;
        elig1 = m1_req & ~m1_done_q;
        if (elig0 && elig1) begin
            pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
            pick = elig1;
        end
        grant = (state_q == ST_IDLE) & (elig0 | elig1);
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        m0_done_d  = 1'b0;
        m1_done_d  = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_ACCESS;
                    sel_d   = pick;
                    last_d  = pick;
                    we_d    = pick ? m1_we    : m0_we;
                    addr_d  = pick ? m1_addr  : m0_addr;
                    wdata_d = pick ? m1_wdata : m0_wdata;
                end
            end
            ST_ACCESS: begin
                state_d = ST_IDLE;
                if (sel_q) begin
                    m1_done_d = 1'b1;
                    if (!we_q) begin
                        m1_rdata_d = mem_rd;
                    end
                end else begin
                    m0_done_d = 1'b1;
                    if (!we_q) begin
                        m0_rdata_d = mem_rd;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            m0_done_q  <= 1'b0;
            m1_done_q  <= 1'b0;
            m0_rdata_q <= 32'h0;
            m1_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_done_q  <= m0_done_d;
            m1_done_q  <= m1_done_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Grants are combinational, so mask them while reset is asserted.
    always_comb begin
        m0_gnt   = grant & ~pick & reset;
        m1_gnt   = grant & pick & reset;
        m0_done  = m0_done_q;
        m1_done  = m1_done_q;
        m0_rdata = m0_rdata_q;
        m1_rdata = m1_rdata_q;
        mem_we   = (state_q == ST_ACCESS) & we_q;
        mem_addr = addr_q;
        mem_wd   = wdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance (a) and a fixed-priority instance (b),
// each with its own small word memory model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_done, m1_gnt, m1_done, a_mem_we;
    logic [31:0] m0_rdata, m1_rdata, a_mem_addr, a_mem_wd, a_mem_rd;

    logic        f0_req = 0, f0_we = 0, f1_req = 0, f1_we = 0;
    logic [31:0] f0_addr = 0, f0_wdata = 0, f1_addr = 0, f1_wdata = 0;
    logic        f0_gnt, f0_done, f1_gnt, f1_done, b_mem_we;
    logic [31:0] f0_rdata, f1_rdata, b_mem_addr, b_mem_wd, b_mem_rd;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];

    dmem_arbiter #(.FIXED_PRIO(0)) dut_a (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wd(a_mem_wd), .mem_rd(a_mem_rd)
    );

    dmem_arbiter #(.FIXED_PRIO(1)) dut_b (
        .clk(clk), .reset(reset),
        .m0_req(f0_req), .m0_we(f0_we), .m0_addr(f0_addr), .m0_wdata(f0_wdata),
        .m0_gnt(f0_gnt), .m0_done(f0_done), .m0_rdata(f0_rdata),
        .m1_req(f1_req), .m1_we(f1_we), .m1_addr(f1_addr), .m1_wdata(f1_wdata),
        .m1_gnt(f1_gnt), .m1_done(f1_done), .m1_rdata(f1_rdata),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wd(b_mem_wd), .mem_rd(b_mem_rd)
    );

    assign a_mem_rd = mem_a[a_mem_addr[7:2]];
    assign b_mem_rd = mem_b[b_mem_addr[7:2]];

    always @(posedge clk) begin
        if (a_mem_we) mem_a[a_mem_addr[7:2]] <= a_mem_wd;
        if (b_mem_we) mem_b[b_mem_addr[7:2]] <= b_mem_wd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        m0_req = 1; m1_req = 1; f0_req = 1; f1_req = 1;
        tick(); tick();
        total++; if ({m0_gnt, m1_gnt, f0_gnt, f1_gnt} !== 4'b0) begin bad++;
            $display("FAIL reset_gnt got=%b exp=0000", {m0_gnt, m1_gnt, f0_gnt, f1_gnt}); end
        total++; if ({m0_done, m1_done, a_mem_we, b_mem_we} !== 4'b0) begin bad++;
            $display("FAIL reset_done_we got=%b exp=0000", {m0_done, m1_done, a_mem_we, b_mem_we}); end
        total++; if ({a_mem_addr, a_mem_wd} !== 64'h0) begin bad++;
            $display("FAIL reset_mem_bus got=%h exp=0", {a_mem_addr, a_mem_wd}); end
        total++; if ({m0_rdata, m1_rdata} !== 64'h0) begin bad++;
            $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata}); end
        m0_req = 0; m1_req = 0; f0_req = 0; f1_req = 0;
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_first_read();
        m0_we = 0; m0_addr = 32'h4; m0_req = 1;
        #1;
        total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++;
            $display("FAIL first_gnt got=%b exp=10", {m0_gnt, m1_gnt}); end
        tick();
        total++; if ({m0_gnt, a_mem_we, a_mem_addr} !== {2'b00, 32'h4}) begin bad++;
            $display("FAIL first_access got=%h exp=%h", {m0_gnt, a_mem_we, a_mem_addr}, {2'b00, 32'h4}); end
        tick();
        total++; if ({m0_done, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++;
            $display("FAIL first_done got=%h exp=%h", {m0_done, m0_rdata}, {1'b1, 32'hDEADBEEF}); end
        m0_req = 0;
        tick();
        total++; if (m0_done !== 1'b0) begin bad++;
            $display("FAIL first_done_pulse got=%b exp=0", m0_done); end
    endtask

    task automatic test_write_read();
        m1_we = 1; m1_addr = 32'h10; m1_wdata = 32'h12345678; m1_req = 1;
        #1;
        total++; if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++;
            $display("FAIL wr_gnt got=%b exp=01", {m0_gnt, m1_gnt}); end
        total++; if (a_mem_we !== 1'b0) begin bad++;
            $display("FAIL wr_we_idle got=%b exp=0", a_mem_we); end
        tick();
        total++; if ({a_mem_we, a_mem_addr, a_mem_wd} !== {1'b1, 32'h10, 32'h12345678}) begin bad++;
            $display("FAIL wr_access got=%h exp=%h", {a_mem_we, a_mem_addr, a_mem_wd},
                     {1'b1, 32'h10, 32'h12345678}); end
        tick();
        total++; if ({m1_done, a_mem_we} !== 2'b10 || mem_a[4] !== 32'h12345678) begin bad++;
            $display("FAIL wr_done got=%b/%h exp=10/12345678", {m1_done, a_mem_we}, mem_a[4]); end
        m1_req = 0; m1_we = 0;
        m0_we = 0; m0_addr = 32'h10; m0_req = 1;
        #1;
        total++; if ({m0_gnt, m1_gnt} !== 2'b10) begin bad++;
            $display("FAIL rd_b2b_gnt got=%b exp=10", {m0_gnt, m1_gnt}); end
        tick(); tick();
        total++; if ({m0_done, m0_rdata, m1_rdata} !== {1'b1, 32'h12345678, 32'h0}) begin bad++;
            $display("FAIL rd_done got=%h exp=%h", {m0_done, m0_rdata, m1_rdata},
                     {1'b1, 32'h12345678, 32'h0}); end
        m0_req = 0;
        tick();
    endtask

    task automatic test_done_cycle();
        m0_we = 0; m0_addr = 32'h4; m0_req = 1;
        tick(); tick();
        total++; if ({m0_done, m0_gnt} !== 2'b10) begin bad++;
            $display("FAIL dc_no_regrant got=%b exp=10", {m0_done, m0_gnt}); end
        tick();
        total++; if ({m0_done, m0_gnt} !== 2'b01) begin bad++;
            $display("FAIL dc_regrant got=%b exp=01", {m0_done, m0_gnt}); end
        tick(); tick();
        total++; if ({m0_done, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++;
            $display("FAIL dc_done got=%h exp=%h", {m0_done, m0_rdata}, {1'b1, 32'hDEADBEEF}); end
        m0_req = 0;
        m1_we = 0; m1_addr = 32'h4; m1_req = 1;
        #1;
        total++; if ({m0_gnt, m1_gnt} !== 2'b01) begin bad++;
            $display("FAIL dc_m1_gnt got=%b exp=01", {m0_gnt, m1_gnt}); end
        tick(); tick();
        total++; if ({m1_done, m1_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++;
            $display("FAIL dc_m1_done got=%h exp=%h", {m1_done, m1_rdata}, {1'b1, 32'hDEADBEEF}); end
        m1_req = 0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [31:0] addr_exp;
        m0_we = 0; m0_addr = 32'h4; m1_we = 0; m1_addr = 32'h10;
        m0_req = 1; m1_req = 1;
        for (int a = 0; a < 4; a++) begin
            #1;
            total++; if ({m1_gnt, m0_gnt} !== ((a % 2 == 1) ? 2'b10 : 2'b01)) begin bad++;
                $display("FAIL rr_gnt_%0d got=%b", a, {m1_gnt, m0_gnt}); end
            if (a > 0) begin
                total++; if ({m1_done, m0_done} !== ((a % 2 == 1) ? 2'b01 : 2'b10)) begin bad++;
                    $display("FAIL rr_done_%0d got=%b", a, {m1_done, m0_done}); end
            end
            addr_exp = (a % 2 == 1) ? 32'h10 : 32'h4;
            tick();
            total++; if ({m1_gnt, m0_gnt, a_mem_addr} !== {2'b00, addr_exp}) begin bad++;
                $display("FAIL rr_access_%0d got=%h exp=%h", a, {m1_gnt, m0_gnt, a_mem_addr},
                         {2'b00, addr_exp}); end
            tick();
        end
        m0_req = 0; m1_req = 0;
        #1;
        total++; if ({m1_done, m0_done, m1_gnt, m0_gnt} !== 4'b1000) begin bad++;
            $display("FAIL rr_last_done got=%b exp=1000", {m1_done, m0_done, m1_gnt, m0_gnt}); end
        total++; if ({m0_rdata, m1_rdata} !== {32'hDEADBEEF, 32'h12345678}) begin bad++;
            $display("FAIL rr_rdata got=%h exp=%h", {m0_rdata, m1_rdata},
                     {32'hDEADBEEF, 32'h12345678}); end
        tick();
    endtask

    task automatic test_fixed_prio();
        f0_we = 0; f0_addr = 32'h4; f1_we = 0; f1_addr = 32'h4;
        f0_req = 1;
        tick(); tick();
        total++; if ({f0_done, f0_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++;
            $display("FAIL fp_first got=%h exp=%h", {f0_done, f0_rdata}, {1'b1, 32'hDEADBEEF}); end
        f0_req = 0;
        tick();
        // Port 0 was granted last, so only fixed priority gives it this tie.
        f0_req = 1; f1_req = 1;
        #1;
        total++; if ({f1_gnt, f0_gnt} !== 2'b01) begin bad++;
            $display("FAIL fp_tie got=%b exp=01", {f1_gnt, f0_gnt}); end
        tick(); tick();
        total++; if ({f0_done, f1_gnt, f0_gnt} !== 3'b110) begin bad++;
            $display("FAIL fp_m1_alone got=%b exp=110", {f0_done, f1_gnt, f0_gnt}); end
        tick(); tick();
        total++; if ({f1_done, f1_gnt, f0_gnt} !== 3'b101) begin bad++;
            $display("FAIL fp_m0_again got=%b exp=101", {f1_done, f1_gnt, f0_gnt}); end
        tick(); tick();
        f0_req = 0;
        #1;
        total++; if ({f0_done, f1_gnt, f0_gnt} !== 3'b110) begin bad++;
            $display("FAIL fp_m0_low got=%b exp=110", {f0_done, f1_gnt, f0_gnt}); end
        tick(); tick();
        total++; if ({f1_done, f1_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++;
            $display("FAIL fp_m1_done got=%h exp=%h", {f1_done, f1_rdata}, {1'b1, 32'hDEADBEEF}); end
        f1_req = 0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h0; m0_req = 1;
        #1;
        total++; if (m0_gnt !== 1'b1) begin bad++;
            $display("FAIL ra_gnt got=%b exp=1", m0_gnt); end
        tick();
        total++; if ({a_mem_we, a_mem_addr} !== {1'b1, 32'h20}) begin bad++;
            $display("FAIL ra_access got=%h exp=%h", {a_mem_we, a_mem_addr}, {1'b1, 32'h20}); end
        #2;
        reset = 0;
        #1;
        total++; if (a_mem_we !== 1'b0) begin bad++;
            $display("FAIL ra_we_drop got=%b exp=0", a_mem_we); end
        m0_req = 0; m0_we = 0;
        tick();
        total++; if (mem_a[8] !== 32'hAAAA5555 || m0_done !== 1'b0) begin bad++;
            $display("FAIL ra_mem_kept got=%h/%b exp=aaaa5555/0", mem_a[8], m0_done); end
        reset = 1;
        tick();
        total++; if ({m0_done, m1_done, m0_gnt, m1_gnt} !== 4'b0) begin bad++;
            $display("FAIL ra_no_done got=%b exp=0000", {m0_done, m1_done, m0_gnt, m1_gnt}); end
        tick();
        total++; if (mem_a[8] !== 32'hAAAA5555) begin bad++;
            $display("FAIL ra_mem_final got=%h exp=aaaa5555", mem_a[8]); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[1] = 32'hDEADBEEF;
        mem_b[1] = 32'hDEADBEEF;
        mem_a[8] = 32'hAAAA5555;
        #1;
        test_reset();
        test_first_read();
        test_write_read();
        test_done_cycle();
        test_round_robin();
        test_fixed_prio();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

endmodule
